// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_pkg : widths, shift-op encodings and helpers shared by the ALU shifters |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package alu_pkg;

  localparam int ALU_W   = 32;
  localparam int ALU_SHW = 5;

  typedef enum logic {
    SH_SRL = 1'b0,
    SH_SRA = 1'b1
  } sh_op_e;

  // Stage k of the right-shift pipe keeps only the SHW-1-k shift bits still
  // to be applied; this packs those shrinking fields back to back.
  function automatic int s_off(input int shw, input int k);
    return k * (shw - 1) - (k * (k - 1)) / 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rshift_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rshift_stage : one conditional right shift by AMT with zero or sign fill   |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rshift_stage
  import alu_pkg::*;
#(
  parameter int W   = ALU_W,
  parameter int AMT = 1
) (
  input  logic [W-1:0] d_in,
  input  logic         s_bit,
  input  logic         arith,
  output logic [W-1:0] d_out
);

  logic fill;

  always_comb begin
    fill  = (arith == SH_SRA) && d_in[W-1];
    d_out = s_bit ? {{AMT{fill}}, d_in[W-1:AMT]} : d_in;
  end

endmodule

`default_nettype wire

// File: rtl/rshift_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rshift_pipe : 5-stage valid/ready pipelined 32-bit SRL/SRA right shifter   |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rshift_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int SHW   = ALU_SHW,
  parameter int TAGW  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [SHW-1:0]   in_s,
  input  logic             in_arith,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [TAGW-1:0]  out_tag
);

  localparam int NSTG  = SHW;
  localparam int S_TOT = s_off(SHW, NSTG - 1);

  logic [NSTG-1:0]             v_q, v_d;
  logic [NSTG-1:0][WIDTH-1:0]  d_q, d_d;
  logic [NSTG-1:0][TAGW-1:0]   t_q, t_d;
  logic [S_TOT-1:0]            s_q, s_d;
  logic [NSTG-2:0]             a_q, a_d;

  logic [NSTG:0]               rdy;
  logic [NSTG-1:0]             ld;
  logic [NSTG-1:0]             v_in;
  logic [NSTG-1:0]             a_in;
  logic [NSTG-1:0]             s_bit;
  logic [NSTG-1:0][WIDTH-1:0]  d_in;
  logic [NSTG-1:0][WIDTH-1:0]  d_sh;
  logic [NSTG-1:0][TAGW-1:0]   t_in;
  logic [S_TOT-1:0]            s_nxt;

  assign rdy[NSTG] = out_ready;

  for (genvar k = 0; k < NSTG; k++) begin : g_stage
    localparam int OFF = s_off(SHW, k);

    // Ready ripples combinationally so a released stall costs no bubble.
    assign rdy[k] = ~v_q[k] | rdy[k+1];

    if (k == 0) begin : g_first
      assign v_in[k]  = in_valid;
      assign d_in[k]  = in_a;
      assign t_in[k]  = in_tag;
      assign a_in[k]  = in_arith;
      assign s_bit[k] = in_s[0];
      assign s_nxt[OFF+SHW-2:OFF] = in_s[SHW-1:1];
    end else begin : g_rest
      localparam int POFF = s_off(SHW, k - 1);
      assign v_in[k]  = v_q[k-1];
      assign d_in[k]  = d_q[k-1];
      assign t_in[k]  = t_q[k-1];
      assign a_in[k]  = a_q[k-1];
      assign s_bit[k] = s_q[POFF];
      if (k < NSTG - 1) begin : g_srem
        assign s_nxt[OFF+SHW-2-k:OFF] = s_q[POFF+SHW-1-k:POFF+1];
      end
    end

    rshift_stage #(
      .W   (WIDTH),
      .AMT (1 << k)
    ) u_shift (
      .d_in  (d_in[k]),
      .s_bit (s_bit[k]),
      .arith (a_in[k]),
      .d_out (d_sh[k])
    );

    if (k < NSTG - 1) begin : g_sreg
      assign s_d[OFF+SHW-2-k:OFF] = ld[k] ? s_nxt[OFF+SHW-2-k:OFF] : s_q[OFF+SHW-2-k:OFF];
    end
  end

  // Payload only moves with a valid op, so bubbles never disturb out_y.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    t_d = t_q;
    a_d = a_q;
    ld  = '0;
    for (int k = 0; k < NSTG; k++) begin
      ld[k] = rdy[k] & v_in[k];
      if (rdy[k]) begin
        v_d[k] = v_in[k];
      end
      if (ld[k]) begin
        d_d[k] = d_sh[k];
        t_d[k] = t_in[k];
      end
    end
    for (int k = 0; k < NSTG - 1; k++) begin
      if (ld[k]) begin
        a_d[k] = a_in[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      d_q <= '0;
      t_q <= '0;
      s_q <= '0;
      a_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
      t_q <= t_d;
      s_q <= s_d;
      a_q <= a_d;
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_q[NSTG-1];
  assign out_y     = d_q[NSTG-1];
  assign out_tag   = t_q[NSTG-1];

endmodule

`default_nettype wire

// File: tb/tb_rshift_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rshift_pipe : scoreboard bench for the pipelined right shifter          |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_rshift_pipe;
  import alu_pkg::*;

  localparam int W  = 32;
  localparam int SW = 5;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [SW-1:0] in_s;
  logic          in_arith;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_y;
  logic [TW-1:0] out_tag;

  typedef struct packed {
    logic [W-1:0]  y;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_err    = 0;
  int   n_in     = 0;
  int   n_out    = 0;
  bit   rnd_done = 1'b0;

  rshift_pipe #(.WIDTH(W), .SHW(SW), .TAGW(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_s      (in_s),
    .in_arith  (in_arith),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] ref_sh(input logic [W-1:0] a, input logic [SW-1:0] s,
                                          input logic ar);
    return ar ? W'($signed(a) >>> s) : (a >> s);
  endfunction

  // Present one op, hold it until accepted, and queue its expected result.
  task automatic send(input logic [W-1:0] a, input logic [SW-1:0] s, input logic ar,
                      input logic [TW-1:0] tag, input logic [W-1:0] y);
    bit acc = 1'b0;
    int guard = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_s     = s;
    in_arith = ar;
    in_tag   = tag;
    while (!acc && guard < 200) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        exp_q.push_back('{y: y, tag: tag});
        n_in++;
      end
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) check("send_accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int g = 0;
    while (exp_q.size() != 0 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_y", 64'(out_y), 64'(mon_e.y));
        check("out_tag", 64'(out_tag), 64'(mon_e.tag));
        n_out++;
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  logic [W-1:0]  bp_a  [7] = '{32'hF000_000F, 32'hF000_000F, 32'hF000_000F, 32'hF000_000F,
                               32'hF000_000F, 32'hF000_000F, 32'h0000_FFFF};
  logic [SW-1:0] bp_s  [7] = '{5'd0, 5'd4, 5'd4, 5'd8, 5'd28, 5'd31, 5'd16};
  logic          bp_ar [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [W-1:0]  bp_y  [7] = '{32'hF000_000F, 32'h0F00_0000, 32'hFF00_0000, 32'hFFF0_0000,
                               32'h0000_000F, 32'hFFFF_FFFF, 32'h0000_0000};

  initial begin
    int lat;
    int acc0;
    int out0;
    int cnt;
    logic [W-1:0]  a_r;
    logic [SW-1:0] s_r;
    logic          ar_r;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_s      = '0;
    in_arith  = 1'b0;
    in_tag    = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_y", 64'(out_y), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // SRL by 31, with latency counted in edges from the accepting edge.
    out_ready = 1'b1;
    send(32'h8000_0000, 5'd31, SH_SRL, 5'd1, 32'h0000_0001);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("srl_latency_edges", 64'(lat), 64'd5);
    wait_empty("srl_drain");

    send(32'h8000_0000, 5'd4, SH_SRA, 5'd2, 32'hF800_0000);
    send(32'h7FFF_FFF0, 5'd4, SH_SRA, 5'd3, 32'h07FF_FFFF);
    send(32'h1234_5678, 5'd0, SH_SRA, 5'd4, 32'h1234_5678);
    send(32'h8765_4321, 5'd0, SH_SRL, 5'd5, 32'h8765_4321);
    wait_empty("sra_drain");

    fork
      begin : b2b_drv
        for (int i = 0; i < 32; i++) begin
          send(32'hDEAD_BEEF, SW'(i), i[0], TW'(i), ref_sh(32'hDEAD_BEEF, SW'(i), i[0]));
        end
      end
      begin : b2b_mon
        int g;
        g   = 0;
        cnt = 0;
        @(negedge clk);
        while (!out_valid && g < 100) begin
          @(negedge clk);
          g++;
        end
        for (int i = 0; i < 32; i++) begin
          if (out_valid) cnt++;
          if (i < 31) @(negedge clk);
        end
        check("b2b_consecutive", 64'(cnt), 64'd32);
      end
    join
    wait_empty("b2b_drain");

    out_ready = 1'b0;
    acc0 = n_in;
    fork
      begin : bp_drv
        for (int i = 0; i < 7; i++) send(bp_a[i], bp_s[i], bp_ar[i], TW'(10 + i), bp_y[i]);
      end
      begin : bp_mon
        logic [W-1:0]  hy;
        logic [TW-1:0] ht;
        int  unstable;
        bit  have;
        unstable = 0;
        have     = 1'b0;
        hy       = '0;
        ht       = '0;
        repeat (10) begin
          @(negedge clk);
          if (out_valid) begin
            if (!have) begin
              hy   = out_y;
              ht   = out_tag;
              have = 1'b1;
            end else if (out_y !== hy || out_tag !== ht) begin
              unstable++;
            end
          end
        end
        check("bp_accepts", 64'(n_in - acc0), 64'd5);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_held_tag", 64'(ht), 64'd10);
        check("bp_stable", 64'(unstable), 64'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_empty("bp_drain");

    // Three ops in flight when reset hits; none may ever come out.
    for (int i = 0; i < 3; i++) begin
      send(32'hA5A5_0000 + i, SW'(i + 1), 1'b1, TW'(20 + i),
           ref_sh(32'hA5A5_0000 + i, SW'(i + 1), 1'b1));
    end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_y", 64'(out_y), 64'd0);
    exp_q.delete();
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("midrst_no_stale", 64'(cnt), 64'd0);
    @(posedge clk);
    #1;
    send(32'h8000_0001, 5'd1, SH_SRA, 5'd9, 32'hC000_0000);
    wait_empty("midrst_next_op");

    out0 = n_out;
    fork
      begin : rnd_drv
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(0, 1) == 0) begin
            @(posedge clk);
            #1;
          end
          a_r  = $urandom;
          s_r  = SW'($urandom_range(0, 31));
          ar_r = 1'($urandom_range(0, 1));
          send(a_r, s_r, ar_r, TW'(i), ref_sh(a_r, s_r, ar_r));
        end
        rnd_done = 1'b1;
      end
      begin : rnd_rdy
        while (!rnd_done) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    wait_empty("rnd_drain");
    check("rnd_count_out", 64'(n_out - out0), 64'd10000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
